countdown_timer_ctrl: RTL and testbench
=======================================

// Module: countdown_timer_ctrl
// PURPOSE
//  Sequences the mm:ss countdown that follows time-setting. Latches the BCD time
//  from the time-set service and runs a start/pause/resume countdown at 1 Hz.
//  Raises done at 00:00 and drives the 4-digit display value plus blank mask.
//  Sits between the time-set service and the 7-segment display driver.
// PARAMETERS
//  TICK_DIV   100_000_000  clk cycles per 1 s tick (>=2)
//  BLINK_DIV  50_000_000   clk cycles per blink phase in PAUSE/DONE (>=1)
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  reset      in   1   synchronous, active-high reset
//  load_en    in   1   set-time-complete level; sampled only in IDLE
//  load_num   in   16  BCD m1 m0 s1 s0 at [15:12][11:8][7:4][3:0]
//  start      in   1   1-cycle pulse, debounced upstream: start/pause/resume/ack
//  clear      in   1   1-cycle pulse: abort to IDLE
//  num        out  16  remaining time, same BCD layout as load_num
//  blank      out  1   1 = display off for this blink phase
//  running    out  1   1 while in RUN
//  done       out  1   1 while in DONE
//  state      out  3   IDLE=0 LOADED=1 RUN=2 PAUSE=3 DONE=4 (debug)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. On reset: state=IDLE,
//    num=0, blank=0, running=0, done=0, prescaler=0, blink counter=0.
//  - Priority each cycle: reset > clear > start > tick.
//  - clear in any state -> IDLE, num=0, prescaler=0, blank=0.
//  - IDLE: when load_en=1, latch load_num into num with sanitising:
//    any digit >9 -> 9; s1 >5 -> 5. Sanitised value 0000 -> stay IDLE, num=0.
//    Otherwise go to LOADED next cycle. start is ignored in IDLE.
//  - LOADED: start -> RUN, prescaler=0. load_en is ignored.
//  - RUN: prescaler counts 0..TICK_DIV-1. tick is asserted on the cycle
//    prescaler==TICK_DIV-1. First decrement occurs TICK_DIV cycles after entry.
//    On tick, BCD decrement with borrow chain:
//    s0 0->9 borrows s1; s1 0->5 borrows m0; m0 0->9 borrows m1.
//    If num==0001 at tick -> num=0000 and state=DONE on the same edge.
//  - RUN + start -> PAUSE. The prescaler value is retained. A tick coincident
//    with start is discarded (start wins).
//  - PAUSE: num frozen. start -> RUN, resuming from the retained prescaler.
//  - DONE: num=0000, done=1. start or clear -> IDLE.
//  - Return to IDLE with load_en still high -> reload on the next cycle.
//    This is intended: start at DONE re-arms the last set time.
//  - blank: blink counter runs only in PAUSE/DONE, 0..BLINK_DIV-1; blank toggles
//    at wrap. Counter and blank are forced to 0 in all other states.
//  - running, done and state are registered and update on the same edge as
//    the state change.
//  - Arithmetic is BCD only. No binary intermediates. num never holds a digit >9
//    or s1 >5.
// TESTING (TICK_DIV=4, BLINK_DIV=2)
//  1 load_en=1, load_num=16'h0102 -> LOADED, num=0102; start ->
//    num 0101, 0100, 0059, 0058 on successive ticks, 4 cycles apart.
//  2 load 16'h0002, start, run 2 ticks -> num=0000, state=DONE, done=1.
//    blank toggles every 2 cycles. start -> IDLE, done=0.
//  3 RUN with prescaler=2, pulse start -> PAUSE, num frozen for 20 cycles.
//    start -> next tick after exactly 2 cycles (prescaler retained).
//  4 load_num=16'h9A7F -> num=9959; load_num=0000 -> stays IDLE;
//    start in IDLE has no effect.
//  5 start and tick in the same cycle -> PAUSE, no decrement.
//    clear and start in the same cycle -> IDLE, num=0.
//  6 Assert reset mid-RUN at num=0530 -> next cycle all outputs zero,
//    state=IDLE. Check 1000 -> 0959 -> 0958 borrow across all digits.

Source files
------------

// File: rtl/countdown_timer_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_timer_ctrl
//
// Purpose:
//   Runs the mm:ss countdown that follows time-setting. Latches a sanitised
//   BCD time from the time-set service, then counts it down at one step per
//   TICK_DIV clocks with start/pause/resume control. Reports done at 00:00
//   and drives the 4-digit display value plus a blink blank mask.
//
// Ports:
//   clk       in   1   system clock, all logic on posedge
//   reset     in   1   synchronous, active-high reset
//   load_en   in   1   set-time-complete level, only looked at in IDLE
//   load_num  in   16  BCD time m1 m0 s1 s0 at [15:12][11:8][7:4][3:0]
//   start     in   1   single-cycle pulse: start / pause / resume / ack
//   clear     in   1   single-cycle pulse: abort to IDLE
//   num       out  16  remaining time, same BCD layout as load_num
//   blank     out  1   1 = display off for the current blink phase
//   running   out  1   1 while in RUN
//   done      out  1   1 while in DONE
//   state     out  3   IDLE=0 LOADED=1 RUN=2 PAUSE=3 DONE=4 (debug)
//
// Control interface: start and clear are single-cycle pulses with no
// handshake. Each is acted on in the cycle it is high; there is no ready
// back-pressure and nothing is queued. When several events coincide the
// order of precedence is reset > clear > start > tick.
// ---------------------------------------------------------------------------
module countdown_timer_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [15:0] load_num,
    input  logic        start,
    input  logic        clear,
    output logic [15:0] num,
    output logic        blank,
    output logic        running,
    output logic        done,
    output logic [2:0]  state
);

    localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q;
    logic [PW-1:0] prescaler;
    logic [BW-1:0] blink_cnt;

    // Clamp each digit to its legal range: any digit above 9 becomes 9,
    // and the tens-of-seconds digit is further limited to 5.
    function automatic logic [15:0] sanitize(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        m1 = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
        m0 = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        s1 = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
        s0 = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        return {m1, m0, s1, s0};
    endfunction

    // One-second BCD decrement with a digit-wise borrow chain.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        m1 = v[15:12];
        m0 = v[11:8];
        s1 = v[7:4];
        s0 = v[3:0];
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = (m1 != 4'd0) ? (m1 - 4'd1) : 4'd9;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    logic [15:0] load_san;
    logic [15:0] num_dec;
    logic        tick;
    logic        blink_wrap;

    assign load_san   = sanitize(load_num);
    assign num_dec    = bcd_dec(num);
    assign tick       = (state_q == S_RUN) && (prescaler == PRESC_LAST);
    assign blink_wrap = (blink_cnt == BLINK_LAST);
    assign state      = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            num       <= 16'h0000;
            prescaler <= '0;
            blink_cnt <= '0;
            blank     <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else if (clear) begin
            state_q   <= S_IDLE;
            num       <= 16'h0000;
            prescaler <= '0;
            blink_cnt <= '0;
            blank     <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Blink is held at zero unless a PAUSE/DONE branch below keeps
            // it running; this also zeroes it on the edge that leaves those
            // states so RUN/IDLE never show a blanked display.
            blink_cnt <= '0;
            blank     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (load_en) begin
                        if (load_san == 16'h0000) begin
                            num <= 16'h0000;
                        end else begin
                            num     <= load_san;
                            state_q <= S_LOADED;
                        end
                    end
                end

                S_LOADED: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        running   <= 1'b1;
                        prescaler <= '0;
                    end
                end

                S_RUN: begin
                    if (start) begin
                        // Pause keeps the prescaler so resume completes the
                        // interrupted second; a coincident tick is dropped.
                        state_q <= S_PAUSE;
                        running <= 1'b0;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (num == 16'h0001) begin
                            num     <= 16'h0000;
                            state_q <= S_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            num <= num_dec;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end

                S_PAUSE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        running <= 1'b1;
                    end else begin
                        blink_cnt <= blink_wrap ? '0 : (blink_cnt + BW'(1));
                        blank     <= blink_wrap ? ~blank : blank;
                    end
                end

                S_DONE: begin
                    if (start) begin
                        // Acknowledge; if load_en is still high IDLE reloads
                        // the last set time on the following cycle.
                        state_q <= S_IDLE;
                        done    <= 1'b0;
                        num     <= 16'h0000;
                    end else begin
                        blink_cnt <= blink_wrap ? '0 : (blink_cnt + BW'(1));
                        blank     <= blink_wrap ? ~blank : blank;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    num     <= 16'h0000;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with TICK_DIV=4, BLINK_DIV=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so they show the result of the edge just taken.
module tb_countdown_timer_ctrl;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [15:0] load_num;
  logic        start;
  logic        clear;
  logic [15:0] num;
  logic        blank;
  logic        running;
  logic        done;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  countdown_timer_ctrl #(
    .TICK_DIV  (4),
    .BLINK_DIV (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .load_num (load_num),
    .start    (start),
    .clear    (clear),
    .num      (num),
    .blank    (blank),
    .running  (running),
    .done     (done),
    .state    (state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single checking task
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_en  = 1'b1;
    load_num = v;
    step();
    load_en  = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    load_en  = 1'b0;
    load_num = 16'h0000;
    start    = 1'b0;
    clear    = 1'b0;
    step(2);
    reset = 1'b0;

    // reset state
    check("rst_state",   16'(state),   16'd0);
    check("rst_num",     num,          16'h0000);
    check("rst_blank",   16'(blank),   16'd0);
    check("rst_running", 16'(running), 16'd0);
    check("rst_done",    16'(done),    16'd0);

    // 1: load 0102 and count down
    do_load(16'h0102);
    check("t1_state_loaded", 16'(state), 16'd1);
    check("t1_num_loaded",   num,        16'h0102);
    pulse_start();
    check("t1_state_run", 16'(state),   16'd2);
    check("t1_running",   16'(running), 16'd1);
    step(3);
    check("t1_no_early_tick", num, 16'h0102);
    step(1);
    check("t1_tick1", num, 16'h0101);
    step(4);
    check("t1_tick2", num, 16'h0100);
    step(4);
    check("t1_tick3_borrow", num, 16'h0059);
    step(4);
    check("t1_tick4", num, 16'h0058);
    pulse_clear();
    check("t1_clear_state", 16'(state), 16'd0);
    check("t1_clear_num",   num,        16'h0000);

    // 2: run to DONE, blink, acknowledge
    do_load(16'h0002);
    pulse_start();
    step(4);
    check("t2_tick1", num, 16'h0001);
    step(4);
    check("t2_num_zero",   num,          16'h0000);
    check("t2_state_done", 16'(state),   16'd4);
    check("t2_done",       16'(done),    16'd1);
    check("t2_running",    16'(running), 16'd0);
    check("t2_blank0", 16'(blank), 16'd0);
    step();
    check("t2_blank1", 16'(blank), 16'd0);
    step();
    check("t2_blank2", 16'(blank), 16'd1);
    step();
    check("t2_blank3", 16'(blank), 16'd1);
    step();
    check("t2_blank4", 16'(blank), 16'd0);
    pulse_start();
    check("t2_ack_state", 16'(state), 16'd0);
    check("t2_ack_done",  16'(done),  16'd0);

    // 3: pause with prescaler=2, resume completes the second after 2 cycles
    do_load(16'h0102);
    pulse_start();
    step(2);
    pulse_start();
    check("t3_pause_state",   16'(state),   16'd3);
    check("t3_pause_running", 16'(running), 16'd0);
    step(20);
    check("t3_frozen_num",   num,        16'h0102);
    check("t3_frozen_state", 16'(state), 16'd3);
    pulse_start();
    check("t3_resume_state", 16'(state), 16'd2);
    check("t3_resume_blank", 16'(blank), 16'd0);
    step();
    check("t3_resume_c1", num, 16'h0102);
    step();
    check("t3_resume_c2", num, 16'h0101);
    pulse_clear();

    // 4: sanitising, zero load, start in IDLE
    do_load(16'h9A7F);
    check("t4_sanitise", num,        16'h9959);
    check("t4_loaded",   16'(state), 16'd1);
    pulse_clear();
    do_load(16'h0000);
    check("t4_zero_state", 16'(state), 16'd0);
    check("t4_zero_num",   num,        16'h0000);
    step();
    check("t4_zero_stay", 16'(state), 16'd0);
    pulse_start();
    check("t4_start_idle", 16'(state), 16'd0);

    // 5: start coincident with tick, clear coincident with start
    do_load(16'h0102);
    pulse_start();
    step(3);
    pulse_start();
    check("t5_tick_start_state", 16'(state), 16'd3);
    check("t5_tick_start_num",   num,        16'h0102);
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    check("t5_clr_start_state", 16'(state), 16'd0);
    check("t5_clr_start_num",   num,        16'h0000);

    // 6: reset mid-RUN, then full borrow chain
    do_load(16'h0531);
    pulse_start();
    step(4);
    check("t6_pre_reset", num, 16'h0530);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_state",   16'(state),   16'd0);
    check("t6_rst_num",     num,          16'h0000);
    check("t6_rst_running", 16'(running), 16'd0);
    check("t6_rst_done",    16'(done),    16'd0);
    check("t6_rst_blank",   16'(blank),   16'd0);
    do_load(16'h1000);
    pulse_start();
    step(4);
    check("t6_borrow_all", num, 16'h0959);
    step(4);
    check("t6_after_borrow", num, 16'h0958);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
